// File: rtl/bsg_manycore_drlp_slave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_manycore_drlp_slave_ctrl
//  Purpose  : Per-PE receive end of the DRLP master->slave weight interface.
//             Captures this PE's weight/bias slice, then streams the words
//             (weights first, bias last) one per handshake into the local
//             MAC datapath. Reports pe_ready/slave_done back to the master.
//  Options  : DRLP_SLAVE_PERF_CNT_EN adds busy_cycles_o, a saturating count
//             of stalled stream cycles (valid high, no yumi).
//  Revision : 1.0  initial release
// ============================================================================
module bsg_manycore_drlp_slave_ctrl #(
    parameter int data_width_p      = 32,
    parameter int wgt_words_p       = 18,
    parameter int imem_addr_width_p = 13
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  pe_data_v_i,
    input  logic [data_width_p*wgt_words_p-1:0]   wgt_i,
    input  logic [data_width_p-1:0]               bias_i,
    input  logic                                  sld_i,
    input  logic [imem_addr_width_p-1:0]          imem_r_addr_i,
    input  logic                                  dw_wgt_start_i,
    output logic                                  wgt_v_o,
    output logic [data_width_p-1:0]               wgt_data_o,
    output logic                                  wgt_last_o,
    input  logic                                  wgt_yumi_i,
    output logic [imem_addr_width_p-1:0]          imem_addr_o,
    output logic                                  pe_ready_o,
    output logic                                  slave_done_o
`ifdef DRLP_SLAVE_PERF_CNT_EN
    ,
    output logic [31:0]                           busy_cycles_o
`endif
);

    // Counter spans weight words plus one slot for the bias word.
    localparam int                CNT_W    = $clog2(wgt_words_p + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(wgt_words_p);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOADED = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]                         state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [data_width_p*wgt_words_p-1:0] wgt_q;
    logic [data_width_p-1:0]            bias_q;
    logic [imem_addr_width_p-1:0]       imem_addr_q;
    logic                               load_en;
    logic                               start_en;

    // Flat view of the held slice: entries 0..N-1 are weights, entry N is bias.
    logic [data_width_p-1:0] words_w [wgt_words_p+1];

    generate
        for (genvar gi = 0; gi < wgt_words_p; gi++) begin : g_words
            assign words_w[gi] = wgt_q[gi*data_width_p +: data_width_p];
        end
    endgenerate
    assign words_w[wgt_words_p] = bias_q;

    // State and stream-position registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; sld aborts everywhere except where a capture wins in IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_en  = 1'b0;
        start_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pe_data_v_i) begin
                    state_d = ST_LOADED;
                    load_en = 1'b1;
                end
                cnt_d = '0;
            end
            ST_LOADED: begin
                if (sld_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (dw_wgt_start_i) begin
                    state_d  = ST_STREAM;
                    cnt_d    = '0;
                    start_en = 1'b1;
                end
            end
            ST_STREAM: begin
                if (sld_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (wgt_yumi_i) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (sld_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (dw_wgt_start_i) begin
                    state_d  = ST_STREAM;
                    cnt_d    = '0;
                    start_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Held slice and imem address; the slice survives aborts and re-streams.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wgt_q       <= '0;
            bias_q      <= '0;
            imem_addr_q <= '0;
        end else begin
            if (load_en) begin
                wgt_q  <= wgt_i;
                bias_q <= bias_i;
            end
            if (start_en) begin
                imem_addr_q <= imem_r_addr_i;
            end
        end
    end

    // Moore outputs decoded from the registered state and counter.
    always_comb begin
        wgt_v_o      = (state_q == ST_STREAM);
        wgt_last_o   = (state_q == ST_STREAM) && (cnt_q == LAST_CNT);
        wgt_data_o   = words_w[cnt_q];
        imem_addr_o  = imem_addr_q;
        pe_ready_o   = (state_q == ST_IDLE);
        slave_done_o = (state_q == ST_DONE);
    end

`ifdef DRLP_SLAVE_PERF_CNT_EN
    logic [31:0] busy_q;

    // Saturating count of stalled stream cycles, cleared on layer restart.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q <= '0;
        end else if (sld_i) begin
            busy_q <= '0;
        end else if ((state_q == ST_STREAM) && !wgt_yumi_i && (busy_q != 32'hFFFF_FFFF)) begin
            busy_q <= busy_q + 32'd1;
        end
    end

    assign busy_cycles_o = busy_q;
`endif

`ifndef SYNTHESIS
    // The MAC may only consume a word that is actually offered.
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        wgt_yumi_i |-> wgt_v_o);
`endif

endmodule
`default_nettype wire
